// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and constants for the cache fill arbiter: state encoding,
// block geometry and default memory latency.
package cache_fill_arbiter_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int MEM_LATENCY     = 4;
  localparam int BLOCK_OFFSET_W  = 4;
  localparam int ADDR_W          = 16;
  localparam int IDX_W           = 3;
  localparam int BASE_W          = ADDR_W - BLOCK_OFFSET_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_D = 2'd1,
    FILL_I = 2'd2
  } fillState_t;

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Miss, memory-read and cache-fill signals between the arbiter (master side)
// and the caches/memory around it (slave side).
interface cache_fill_arbiter_if;
  import cache_fill_arbiter_pkg::*;

  logic              i_miss;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              mem_data_valid;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              i_fill_we;
  logic              d_fill_we;
  logic [IDX_W-1:0]  fill_idx;
  logic              i_tag_we;
  logic              d_tag_we;
  logic              i_stall;
  logic              d_stall;
  logic              busy;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid,
    output mem_en, mem_addr, i_fill_we, d_fill_we, fill_idx,
           i_tag_we, d_tag_we, i_stall, d_stall, busy
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid,
    input  mem_en, mem_addr, i_fill_we, d_fill_we, fill_idx,
           i_tag_we, d_tag_we, i_stall, d_stall, busy
  );

endinterface

// File: rtl/cache_fill_arbiter_fill_word_counter.sv
// Word-within-block counter with synchronous clear; tc flags the last word so
// the owner can stop issuing or finish the fill.
module fill_word_counter
  import cache_fill_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [IDX_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == '1);

endmodule

// File: rtl/cache_fill_arbiter.sv
// Cache fill arbiter: grants one I- or D-cache block refill at a time (D first),
// streams word reads to memory and steers returning words into the owning cache.
module cache_fill_arbiter #(
  parameter int WORDS_PER_BLOCK = cache_fill_arbiter_pkg::WORDS_PER_BLOCK,
  parameter int MEM_LATENCY     = cache_fill_arbiter_pkg::MEM_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_fill_arbiter_if.master bus
);
  import cache_fill_arbiter_pkg::*;

  // state  | meaning
  // IDLE   | no fill in flight; arbitrate pending misses, D over I
  // FILL_D | D-cache block being requested and written
  // FILL_I | I-cache block being requested and written

  // Counters are fixed at 3 bits, so the block must be exactly eight words.
  if (WORDS_PER_BLOCK != (1 << IDX_W) || MEM_LATENCY < 1) begin : gParamCheck
    $error("cache_fill_arbiter: WORDS_PER_BLOCK must be %0d and MEM_LATENCY >= 1", 1 << IDX_W);
  end

  fillState_t        state;
  fillState_t        stateNext;
  logic [BASE_W-1:0] base;
  logic              issueDone;
  logic              filling;
  logic              issueEn;
  logic              recvEn;
  logic              issueTc;
  logic              recvTc;
  logic              grant;
  logic [IDX_W-1:0]  issueCnt;
  logic [IDX_W-1:0]  recvCnt;
  logic              unusedOffsets;

  assign filling = (state != IDLE);
  assign issueEn = filling && !issueDone;
  assign recvEn  = filling && bus.mem_data_valid;
  assign grant   = (state == IDLE) && (bus.d_miss || bus.i_miss);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (bus.d_miss) begin
          stateNext = FILL_D;
        end else if (bus.i_miss) begin
          stateNext = FILL_I;
        end
      end
      FILL_D, FILL_I: begin
        if (recvEn && recvTc) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // issueDone stops mem_en after the last word while responses are still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base      <= '0;
      issueDone <= 1'b0;
    end else begin
      if (grant) begin
        base <= bus.d_miss ? bus.d_miss_addr[ADDR_W-1:BLOCK_OFFSET_W]
                           : bus.i_miss_addr[ADDR_W-1:BLOCK_OFFSET_W];
      end
      if (!filling) begin
        issueDone <= 1'b0;
      end else if (issueEn && issueTc) begin
        issueDone <= 1'b1;
      end
    end
  end

  fill_word_counter uIssueCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (issueEn),
    .clr   (!filling),
    .cnt   (issueCnt),
    .tc    (issueTc)
  );

  fill_word_counter uRecvCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (recvEn),
    .clr   (!filling),
    .cnt   (recvCnt),
    .tc    (recvTc)
  );

  assign bus.mem_en    = issueEn;
  assign bus.mem_addr  = issueEn ? {base, issueCnt, 1'b0} : '0;
  assign bus.d_fill_we = (state == FILL_D) && bus.mem_data_valid;
  assign bus.i_fill_we = (state == FILL_I) && bus.mem_data_valid;
  assign bus.fill_idx  = recvCnt;
  assign bus.d_tag_we  = bus.d_fill_we && recvTc;
  assign bus.i_tag_we  = bus.i_fill_we && recvTc;
  assign bus.d_stall   = bus.d_miss || (state == FILL_D);
  assign bus.i_stall   = bus.i_miss || (state == FILL_I);
  assign bus.busy      = filling;

  // Byte offset within the block never affects the fill; the block always starts at word 0.
  assign unusedOffsets = ^{bus.i_miss_addr[BLOCK_OFFSET_W-1:0],
                           bus.d_miss_addr[BLOCK_OFFSET_W-1:0]};

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: directed miss scenarios plus random traffic,
// compared every cycle against a transaction-level model of the arbiter.
module tb_cache_fill_arbiter;
  import cache_fill_arbiter_pkg::*;

  localparam int WPB = 8;
  localparam int LAT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_fill_arbiter_if bus();

  cache_fill_arbiter #(
    .WORDS_PER_BLOCK (WPB),
    .MEM_LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nChecks = 0;
  int nErrors = 0;

  // Model: owner 0 = none, 1 = D, 2 = I; block base as a byte address / 16.
  int owner = 0;
  int mBase = 0;
  int issued = 0;
  int received = 0;
  int expTagsD = 0;
  int expTagsI = 0;
  int tagsD = 0;
  int tagsI = 0;
  int lastTagD = 0;
  int lastTagI = 0;
  int cycleNo = 0;
  bit doneD = 0;
  bit doneI = 0;
  bit randomGaps = 0;
  bit spurious = 0;
  int reqQ[$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycleNo);
    end
  endtask

  task automatic compareOutputs();
    bit expEn;
    bit wr;
    int expAddr;
    expEn   = (owner != 0) && (issued < WPB);
    expAddr = expEn ? (mBase * 16 + issued * 2) : 0;
    wr      = (owner != 0) && bus.mem_data_valid;
    checkVal("mem_en",    bus.mem_en, expEn);
    checkVal("mem_addr",  bus.mem_addr, expAddr);
    checkVal("d_fill_we", bus.d_fill_we, wr && owner == 1);
    checkVal("i_fill_we", bus.i_fill_we, wr && owner == 2);
    checkVal("fill_idx",  bus.fill_idx, received);
    checkVal("d_tag_we",  bus.d_tag_we, wr && owner == 1 && received == WPB - 1);
    checkVal("i_tag_we",  bus.i_tag_we, wr && owner == 2 && received == WPB - 1);
    checkVal("d_stall",   bus.d_stall, bus.d_miss || owner == 1);
    checkVal("i_stall",   bus.i_stall, bus.i_miss || owner == 2);
    checkVal("busy",      bus.busy, owner != 0);
    checkVal("strobe_excl", (bus.i_fill_we | bus.i_tag_we) & (bus.d_fill_we | bus.d_tag_we), 0);
    if (bus.d_tag_we === 1'b1) begin tagsD++; lastTagD = cycleNo; end
    if (bus.i_tag_we === 1'b1) begin tagsI++; lastTagI = cycleNo; end
  endtask

  task automatic stepModel();
    if (owner == 0) begin
      issued   = 0;
      received = 0;
      if (bus.d_miss) begin
        owner = 1;
        mBase = int'(bus.d_miss_addr) / 16;
      end else if (bus.i_miss) begin
        owner = 2;
        mBase = int'(bus.i_miss_addr) / 16;
      end
    end else begin
      if (issued < WPB) begin
        reqQ.push_back(cycleNo);
        issued++;
      end
      if (bus.mem_data_valid) begin
        received++;
        if (received == WPB) begin
          if (owner == 1) begin expTagsD++; doneD = 1; end
          else begin expTagsI++; doneI = 1; end
          owner    = 0;
          received = 0;
          issued   = 0;
        end
      end
    end
  endtask

  task automatic driveValid();
    bus.mem_data_valid = 1'b0;
    if (owner != 0 && reqQ.size() > 0 && (cycleNo - reqQ[0]) >= LAT &&
        (!randomGaps || $urandom_range(0, 2) != 0)) begin
      bus.mem_data_valid = 1'b1;
      void'(reqQ.pop_front());
    end else if (owner == 0 && spurious && $urandom_range(0, 1) == 1) begin
      bus.mem_data_valid = 1'b1;
    end
  endtask

  task automatic runCycle();
    @(negedge clk);
    compareOutputs();
    stepModel();
    @(posedge clk);
    cycleNo++;
    #1;
    driveValid();
  endtask

  task automatic runFill(input int budget);
    int n;
    n = 0;
    do begin
      runCycle();
      n++;
    end while (owner != 0 && n < budget);
    if (n >= budget) checkVal("fill_timeout_busy", bus.busy, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_mem_en"},   bus.mem_en, 0);
    checkVal({tag, "_mem_addr"}, bus.mem_addr, 0);
    checkVal({tag, "_fill_we"},  {bus.i_fill_we, bus.d_fill_we}, 0);
    checkVal({tag, "_fill_idx"}, bus.fill_idx, 0);
    checkVal({tag, "_tag_we"},   {bus.i_tag_we, bus.d_tag_we}, 0);
    checkVal({tag, "_busy"},     bus.busy, 0);
    checkVal({tag, "_d_stall"},  bus.d_stall, bus.d_miss);
    checkVal({tag, "_i_stall"},  bus.i_stall, bus.i_miss);
  endtask

  task automatic resetModel();
    owner = 0; issued = 0; received = 0;
    reqQ.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tBefore;
    int iBefore;
    int missCycle;
    int n;

    bus.i_miss = 1'b0; bus.i_miss_addr = '0;
    bus.d_miss = 1'b0; bus.d_miss_addr = '0;
    bus.mem_data_valid = 1'b0;

    #2 bus.i_miss = 1'b1; bus.mem_data_valid = 1'b1;
    #1 checkResetOutputs("rst_i");
    bus.i_miss = 1'b0; bus.d_miss = 1'b1;
    #1 checkResetOutputs("rst_d");
    bus.d_miss = 1'b0; bus.mem_data_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) runCycle();

    // D miss at 0x1234: block 0x1230..0x123E, single tag, nominal latency.
    tBefore = tagsD;
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h1234;
    missCycle = cycleNo;
    runFill(40);
    bus.d_miss = 1'b0;
    checkVal("d_tag_count_1234", tagsD - tBefore, 1);
    checkVal("fill_latency", lastTagD - missCycle, 1 + (LAT - 1) + WPB);
    runCycle();

    // Simultaneous misses: D first, one IDLE cycle, then I.
    tBefore = tagsD; iBefore = tagsI;
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h8000;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0040;
    runFill(40);
    bus.d_miss = 1'b0;
    runFill(40);
    bus.i_miss = 1'b0;
    checkVal("both_d_tags", tagsD - tBefore, 1);
    checkVal("both_i_tags", tagsI - iBefore, 1);
    checkVal("d_before_i", lastTagD < lastTagI, 1);
    checkVal("i_gap", lastTagI - lastTagD, 2 + (LAT - 1) + WPB);
    runCycle();

    // I miss at the top of memory: no wrap past the block.
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'hFFFE;
    runFill(40);
    bus.i_miss = 1'b0;
    runCycle();

    // Reset after the third D word: fill abandoned, held miss refilled.
    tBefore = tagsD;
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h5A5A;
    n = 0;
    while (received < 3 && n < 40) begin runCycle(); n++; end
    if (n >= 40) checkVal("rst_mid_timeout_busy", bus.busy, 0);
    rst_n = 1'b0;
    bus.mem_data_valid = 1'b0;
    resetModel();
    #1 checkResetOutputs("rst_mid");
    @(negedge clk) checkResetOutputs("rst_hold");
    @(posedge clk); cycleNo++;
    #1 rst_n = 1'b1;
    checkVal("rst_abort_no_tag", tagsD - tBefore, 0);
    runFill(40);
    bus.d_miss = 1'b0;
    checkVal("rst_refill_tag", tagsD - tBefore, 1);
    runCycle();

    // D miss dropped after two words, then stray valids while idle.
    tBefore = tagsD;
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h2468;
    n = 0;
    while (received < 2 && n < 40) begin runCycle(); n++; end
    bus.d_miss = 1'b0;
    runFill(40);
    checkVal("drop_tag", tagsD - tBefore, 1);
    tBefore = tagsD; iBefore = tagsI;
    spurious = 1;
    repeat (10) runCycle();
    spurious = 0;
    checkVal("idle_valid_no_tag", (tagsD - tBefore) + (tagsI - iBefore), 0);

    // Random traffic with response gaps and stray idle valids.
    randomGaps = 1; spurious = 1;
    doneD = 0; doneI = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!bus.d_miss && $urandom_range(0, 9) == 0) begin
        bus.d_miss = 1'b1; bus.d_miss_addr = 16'($urandom);
      end
      if (!bus.i_miss && $urandom_range(0, 9) == 0) begin
        bus.i_miss = 1'b1; bus.i_miss_addr = 16'($urandom);
      end
      runCycle();
      if (doneD) begin bus.d_miss = 1'b0; doneD = 0; end
      if (doneI) begin bus.i_miss = 1'b0; doneI = 0; end
      if (bus.d_miss && owner == 1 && $urandom_range(0, 40) == 0) bus.d_miss = 1'b0;
      if (bus.i_miss && owner == 2 && $urandom_range(0, 40) == 0) bus.i_miss = 1'b0;
    end
    bus.d_miss = 1'b0; bus.i_miss = 1'b0;
    spurious = 0;
    runFill(60);
    runCycle();

    checkVal("d_tag_total", tagsD, expTagsD);
    checkVal("i_tag_total", tagsI, expTagsI);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
